// File: rtl/entry_alloc_tracker_pkg.sv
// Shared defaults for the entry allocation tracker. Instantiators normally
// override these with RS/ROB/PRF sizes and the dispatch width.
package entry_alloc_tracker_pkg;
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_REQS  = 3;
endpackage

// File: rtl/psel_gen.sv
// Multi-port priority selector: port i gets a one-hot of the i-th lowest set
// bit of req, or zero when fewer than i+1 bits are set.
module psel_gen #(
  parameter int unsigned REQS  = 3,
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]      req,
  output logic [REQS*WIDTH-1:0] gnt_bus
);
  // rem[i] holds the candidates left after ports 0..i-1 took theirs.
  logic [REQS-1:0][WIDTH-1:0] rem;

  assign rem[0] = req;

  for (genvar i = 0; i < REQS; i++) begin : g_port
    assign gnt_bus[i*WIDTH +: WIDTH] = rem[i] & (~rem[i] + WIDTH'(1));
    if (i < REQS - 1) begin : g_chain
      assign rem[i+1] = rem[i] & ~gnt_bus[i*WIDTH +: WIDTH];
    end
  end
endmodule

// File: rtl/entry_alloc_tracker.sv
// Tracks the free/busy state of WIDTH entries, grants up to REQS entries per
// cycle all-or-nothing, and folds release masks back into the free vector.
module entry_alloc_tracker
  import entry_alloc_tracker_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned REQS  = DEF_REQS,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REQS-1:0]       alloc_req,
  output logic [REQS-1:0]       alloc_gnt,
  output logic [REQS*IDX_W-1:0] alloc_idx,
  output logic                  alloc_stall,
  input  logic [WIDTH-1:0]      release_mask,
  input  logic                  flush,
  output logic [WIDTH-1:0]      free_vec,
  output logic [IDX_W:0]        free_cnt,
  output logic                  empty
);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [WIDTH-1:0]      free_q, free_d;
  logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;
  logic [REQS*WIDTH-1:0] gnt_bus;
  logic [WIDTH-1:0]      gnt_mask;
  logic [CNT_W-1:0]      req_cnt;

  function automatic logic [CNT_W-1:0] popcnt_w(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(WIDTH); i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] popcnt_r(input logic [REQS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(REQS); i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] oh2bin(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(WIDTH); i++) if (oh[i]) b = b | IDX_W'(i);
    return b;
  endfunction

  psel_gen #(.REQS(REQS), .WIDTH(WIDTH)) u_psel (
    .req     (free_q),
    .gnt_bus (gnt_bus)
  );

  always_comb begin
    req_cnt     = popcnt_r(alloc_req);
    alloc_stall = 1'b0;
    alloc_gnt   = '0;
    alloc_idx   = '0;
    gnt_mask    = '0;
    // Reset and flush suppress both grant and stall for the cycle.
    if (!reset && !flush) begin
      if (req_cnt > free_cnt_q) alloc_stall = 1'b1;
      else                      alloc_gnt   = alloc_req;
    end
    for (int i = 0; i < int'(REQS); i++) begin
      if (alloc_gnt[i]) begin
        gnt_mask                     = gnt_mask | gnt_bus[i*WIDTH +: WIDTH];
        alloc_idx[i*IDX_W +: IDX_W]  = oh2bin(gnt_bus[i*WIDTH +: WIDTH]);
      end
    end
    // Released entries join only next cycle; a same-cycle grant keeps them busy.
    if (flush) free_d = '1;
    else       free_d = (free_q | release_mask) & ~gnt_mask;
    free_cnt_d = popcnt_w(free_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_q     <= '1;
      free_cnt_q <= CNT_W'(WIDTH);
    end else begin
      free_q     <= free_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign free_vec = free_q;
  assign free_cnt = free_cnt_q;
  assign empty    = (free_cnt_q == '0);
endmodule

// File: tb/tb_entry_alloc_tracker.sv
// Directed vector table plus a randomized run against a reference free-list
// model for entry_alloc_tracker (WIDTH=8, REQS=3).
module tb_entry_alloc_tracker;
  localparam int W = 8;
  localparam int R = 3;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [R-1:0]  alloc_req;
  logic [R-1:0]  alloc_gnt;
  logic [R*IW-1:0] alloc_idx;
  logic          alloc_stall;
  logic [W-1:0]  release_mask;
  logic          flush;
  logic [W-1:0]  free_vec;
  logic [IW:0]   free_cnt;
  logic          empty;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  entry_alloc_tracker #(.WIDTH(W), .REQS(R)) dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_idx(alloc_idx), .alloc_stall(alloc_stall), .release_mask(release_mask),
    .flush(flush), .free_vec(free_vec), .free_cnt(free_cnt), .empty(empty)
  );

  always @(posedge clock) begin
    assert ((alloc_req & (alloc_req + 3'd1)) == '0)
      else $error("alloc_req not thermometer-coded: %b", alloc_req);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          fl;
    logic [R-1:0]  req;
    logic [W-1:0]  rel;
    logic [R-1:0]  gnt;
    logic [R*IW-1:0] idx;
    logic          stall;
    logic [W-1:0]  free;
    logic [IW:0]   cnt;
  } vec_t;

  vec_t vt [15];

  logic [W-1:0]    free_m;
  logic [R-1:0]    e_gnt;
  logic [R*IW-1:0] e_idx;
  logic            e_stall;
  logic [W-1:0]    e_mask;
  int              n, c, k;

  initial begin
    //        rst fl  req     rel    gnt     idx     stl  free   cnt
    vt[0]  = '{1, 0, 3'b111, 8'h00, 3'b000, 9'h000, 0, 8'hFF, 4'd8};
    vt[1]  = '{0, 0, 3'b111, 8'h00, 3'b111, 9'h088, 0, 8'hF8, 4'd5};
    vt[2]  = '{0, 0, 3'b111, 8'h00, 3'b111, 9'h163, 0, 8'hC0, 4'd2};
    vt[3]  = '{0, 0, 3'b111, 8'h00, 3'b000, 9'h000, 1, 8'hC0, 4'd2};
    vt[4]  = '{0, 0, 3'b011, 8'h00, 3'b011, 9'h03E, 0, 8'h00, 4'd0};
    vt[5]  = '{0, 0, 3'b001, 8'h05, 3'b000, 9'h000, 1, 8'h05, 4'd2};
    vt[6]  = '{0, 0, 3'b111, 8'h00, 3'b000, 9'h000, 1, 8'h05, 4'd2};
    vt[7]  = '{0, 0, 3'b011, 8'h00, 3'b011, 9'h010, 0, 8'h00, 4'd0};
    vt[8]  = '{0, 0, 3'b000, 8'h01, 3'b000, 9'h000, 0, 8'h01, 4'd1};
    vt[9]  = '{0, 0, 3'b001, 8'h81, 3'b001, 9'h000, 0, 8'h80, 4'd1};
    vt[10] = '{0, 0, 3'b001, 8'h00, 3'b001, 9'h007, 0, 8'h00, 4'd0};
    vt[11] = '{0, 1, 3'b001, 8'h00, 3'b000, 9'h000, 0, 8'hFF, 4'd8};
    vt[12] = '{0, 0, 3'b111, 8'hFF, 3'b111, 9'h088, 0, 8'hF8, 4'd5};
    vt[13] = '{1, 0, 3'b111, 8'h00, 3'b000, 9'h000, 0, 8'hFF, 4'd8};
    vt[14] = '{0, 0, 3'b000, 8'h00, 3'b000, 9'h000, 0, 8'hFF, 4'd8};

    reset = 1'b1; flush = 1'b0; alloc_req = '0; release_mask = '0;
    @(posedge clock); #1;

    for (int i = 0; i < 15; i++) begin
      reset = vt[i].rst; flush = vt[i].fl;
      alloc_req = vt[i].req; release_mask = vt[i].rel;
      #4;
      check($sformatf("v%0d gnt", i),   32'(alloc_gnt),   32'(vt[i].gnt));
      check($sformatf("v%0d idx", i),   32'(alloc_idx),   32'(vt[i].idx));
      check($sformatf("v%0d stall", i), 32'(alloc_stall), 32'(vt[i].stall));
      @(posedge clock); #1;
      check($sformatf("v%0d free", i),  32'(free_vec),    32'(vt[i].free));
      check($sformatf("v%0d cnt", i),   32'(free_cnt),    32'(vt[i].cnt));
      check($sformatf("v%0d empty", i), 32'(empty),       32'(vt[i].cnt == 0));
    end

    // Randomized run: state is all-free after the last vector.
    reset = 1'b0;
    free_m = 8'hFF;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      n = $urandom_range(0, R);
      alloc_req = R'((1 << n) - 1);
      release_mask = ($urandom_range(0, 3) == 0) ? W'($urandom) & ~free_m : '0;
      flush = ($urandom_range(0, 99) == 0);
      c = $countones(free_m);
      e_gnt = '0; e_idx = '0; e_stall = 1'b0; e_mask = '0;
      if (!flush) begin
        if (n > c) e_stall = 1'b1;
        else begin
          e_gnt = alloc_req;
          k = 0;
          for (int b = 0; b < W && k < n; b++) begin
            if (free_m[b]) begin
              e_idx[k*IW +: IW] = IW'(b);
              e_mask[b] = 1'b1;
              k++;
            end
          end
        end
      end
      #4;
      check("rnd gnt",   32'(alloc_gnt),   32'(e_gnt));
      check("rnd idx",   32'(alloc_idx),   32'(e_idx));
      check("rnd stall", 32'(alloc_stall), 32'(e_stall));
      for (int p = 0; p < R; p++)
        if (alloc_gnt[p])
          check("rnd gnt_busy", 32'(free_m[alloc_idx[p*IW +: IW]]), 32'd1);
      free_m = flush ? 8'hFF : ((free_m | release_mask) & ~e_mask);
      @(posedge clock); #1;
      check("rnd free",  32'(free_vec), 32'(free_m));
      check("rnd cnt",   32'(free_cnt), 32'($countones(free_m)));
      check("rnd cnt_pop", 32'(free_cnt), 32'($countones(free_vec)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
